// File: rtl/telemetry_pkg.sv
// Shared types, constants and helpers for the pitch telemetry transmitter.
package telemetry_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_HOLD = 3'd3,
    ST_WAIT = 3'd4
  } tx_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic int bytes_per_value(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/pitch_telemetry_tx_if.sv
// UART-side handshake bundle: byte, send pulse and busy back-pressure.
interface pitch_telemetry_tx_if;
  logic [7:0] data_byte_out;
  logic       trigger_out;
  logic       busy_in;

  modport master (output data_byte_out, output trigger_out, input busy_in);
  modport slave  (input data_byte_out, input trigger_out, output busy_in);
endinterface

// File: rtl/telemetry_fifo.sv
// Synchronous frame FIFO; pop data is registered and valid the cycle after pop.
module telemetry_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = dout_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
        dout_q <= mem_q[rptr_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/pitch_telemetry_tx.sv
// Frames pitch values into SYNC/seq/payload byte streams for the UART.
// Define PITCH_TELEMETRY_CHECKSUM_EN to append an XOR checksum byte per frame.
//
// state | meaning
// IDLE  | no frame pending
// LOAD  | pop FIFO head into the frame register, byte index = 0
// SEND  | wait for UART idle, then drive byte and pulse trigger
// HOLD  | one cycle covering the UART busy assertion latency
// WAIT  | wait for UART idle, then next byte / next frame / idle
import telemetry_pkg::*;

module pitch_telemetry_tx #(
  parameter int         WIDTH      = 11,
  parameter int         CHANNELS   = 1,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [CHANNELS*WIDTH-1:0] value_in,
  input  logic                      valid_in,
  pitch_telemetry_tx_if.master      uart,
  output logic                      frame_active_out,
  output logic [15:0]               drop_count_out
);
  localparam int BPV     = bytes_per_value(WIDTH);
  localparam int PAYLOAD = CHANNELS * BPV;
`ifdef PITCH_TELEMETRY_CHECKSUM_EN
  localparam int CS_BYTES = 1;
`else
  localparam int CS_BYTES = 0;
`endif
  localparam int NBYTES = 2 + PAYLOAD + CS_BYTES;
  localparam int IDXW   = $clog2(NBYTES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  tx_state_t                 state_q, state_d;
  logic [IDXW-1:0]           idx_q;
  logic [7:0]                seq_q, data_q, cur_byte;
  logic [15:0]               drop_q;
  logic [CHANNELS*WIDTH-1:0] frame_q;
  logic                      fifo_full, fifo_empty;
  logic                      pop, push_ok, more, send_fire, advance, last_byte;
  logic [7:0]                pay [PAYLOAD];
  logic [8*BPV-1:0]          ext;

  telemetry_fifo #(.WIDTH(CHANNELS*WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push_i  (valid_in),
    .pop_i   (pop),
    .din_i   (value_in),
    .dout_o  (frame_q),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pop       = (state_q == ST_LOAD);
  assign push_ok   = valid_in && (!fifo_full || pop);
  assign more      = !fifo_empty || push_ok;
  assign send_fire = (state_q == ST_SEND) && !uart.busy_in;
  assign advance   = (state_q == ST_WAIT) && !uart.busy_in;
  assign last_byte = (idx_q == LAST_IDX);

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (more) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: if (!uart.busy_in) state_d = ST_HOLD;
      ST_HOLD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!uart.busy_in) begin
          if (!last_byte) state_d = ST_SEND;
          else            state_d = more ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset gates the pulse combinationally so an aborted byte never escapes.
  always_comb begin
    uart.trigger_out   = send_fire && !rst_in;
    uart.data_byte_out = send_fire ? cur_byte : data_q;
    frame_active_out   = (state_q != ST_IDLE);
  end

  assign drop_count_out = drop_q;

  always_comb begin
    ext = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ext = '0;
      ext[WIDTH-1:0] = frame_q[c*WIDTH +: WIDTH];
      for (int j = 0; j < BPV; j++) pay[c*BPV + j] = ext[8*(BPV-1-j) +: 8];
    end
  end

`ifdef PITCH_TELEMETRY_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk_in) begin
    if (rst_in || pop) csum_q <= '0;
    else if (send_fire && idx_q != '0 && !last_byte) csum_q <= csum_q ^ cur_byte;
  end
`endif

  always_comb begin
    cur_byte = SYNC_BYTE;
    if (idx_q == IDXW'(1)) cur_byte = seq_q;
    for (int k = 0; k < PAYLOAD; k++) begin
      if (idx_q == IDXW'(k + 2)) cur_byte = pay[k];
    end
`ifdef PITCH_TELEMETRY_CHECKSUM_EN
    if (last_byte) cur_byte = csum_q;
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx_q  <= '0;
      seq_q  <= '0;
      data_q <= '0;
      drop_q <= '0;
    end else begin
      if (pop) idx_q <= '0;
      else if (advance && !last_byte) idx_q <= idx_q + IDXW'(1);
      if (advance && last_byte) seq_q <= seq_q + 8'd1;
      if (send_fire) data_q <= cur_byte;
      if (valid_in && !push_ok && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_pitch_telemetry_tx.sv
// Directed bench for pitch_telemetry_tx: single- and three-channel instances with a UART busy model.
module tb_pitch_telemetry_tx;
  import telemetry_pkg::*;

`ifdef PITCH_TELEMETRY_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int FL  = 4 + CS;
  localparam int FLB = 8 + CS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [10:0] val = '0;
  logic        vld = 1'b0;
  logic        act;
  logic [15:0] drop;
  logic [47:0] val_b = '0;
  logic        vld_b = 1'b0;
  logic        act_b;
  logic [15:0] drop_b;

  pitch_telemetry_tx_if ua ();
  pitch_telemetry_tx_if ub ();

  logic hold_busy = 1'b0;
  int   busy_len = 10;
  int   bcnt = 0;
  logic start = 1'b0;
  assign ua.busy_in = hold_busy || (bcnt != 0);
  assign ub.busy_in = 1'b0;

  pitch_telemetry_tx dut (
    .clk_in(clk), .rst_in(rst), .value_in(val), .valid_in(vld),
    .uart(ua), .frame_active_out(act), .drop_count_out(drop)
  );

  pitch_telemetry_tx #(.WIDTH(16), .CHANNELS(3)) dut_b (
    .clk_in(clk), .rst_in(rst), .value_in(val_b), .valid_in(vld_b),
    .uart(ub), .frame_active_out(act_b), .drop_count_out(drop_b)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0, first_cyc = 0, vcyc = 0;
  logic [7:0] cap_q[$];
  logic [7:0] capb_q[$];

  logic [7:0] exp_f1 [5] = '{8'hA5, 8'h00, 8'h05, 8'hA3, 8'hA6};
  logic [7:0] exp_f2 [5] = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00};
  logic [7:0] exp_b  [9] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'hBF};

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy rises the cycle after a trigger and lasts busy_len cycles.
  always @(negedge clk) begin
    if (bcnt != 0) bcnt = bcnt - 1;
    if (start) bcnt = busy_len;
    start = ua.trigger_out;
    if (ua.trigger_out) begin
      if (cap_q.size() == 0) first_cyc = cyc;
      cap_q.push_back(ua.data_byte_out);
    end
    if (ub.trigger_out) capb_q.push_back(ub.data_byte_out);
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic int qa(input int i);
    return (i < cap_q.size()) ? int'(cap_q[i]) : -1;
  endfunction

  function automatic int qb(input int i);
    return (i < capb_q.size()) ? int'(capb_q[i]) : -1;
  endfunction

  task automatic send(input logic [10:0] v);
    @(negedge clk);
    val = v; vld = 1'b1; vcyc = cyc;
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit to);
    int k = 0;
    repeat (2) @(negedge clk);
    while (act && k < budget) begin
      @(negedge clk);
      k++;
    end
    to = (k >= budget);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cap_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit to;
    int tos, errs, k;
    logic found;

    repeat (3) @(negedge clk);
    check_val("rst_data", ua.data_byte_out, 0);
    check_val("rst_trig", ua.trigger_out, 0);
    check_val("rst_active", act, 0);
    check_val("rst_drop", drop, 0);
    rst = 1'b0;

    // three channels, 16-bit values
    @(negedge clk);
    val_b = {16'h00FF, 16'hABCD, 16'h1234}; vld_b = 1'b1;
    @(negedge clk);
    vld_b = 1'b0;
    repeat (40) @(negedge clk);
    check_val("mc_len", capb_q.size(), FLB);
    for (int i = 0; i < FLB; i++) check_val($sformatf("mc_byte%0d", i), qb(i), exp_b[i]);

    // basic frame and latency
    busy_len = 10;
    cap_q.delete();
    @(negedge clk);
    val = 11'h5A3; vld = 1'b1; vcyc = cyc;
    @(negedge clk);
    vld = 1'b0;
    check_val("load_active", act, 1);
    wait_done(400, to);
    check_val("basic_timeout", to, 0);
    check_val("basic_lat", first_cyc - vcyc, 2);
    check_val("basic_len", cap_q.size(), FL);
    for (int i = 0; i < FL; i++) check_val($sformatf("f1_byte%0d", i), qa(i), exp_f1[i]);
    check_val("hold_last", ua.data_byte_out, exp_f1[FL-1]);

    cap_q.delete();
    send(11'h001);
    wait_done(400, to);
    check_val("f2_timeout", to, 0);
    check_val("f2_len", cap_q.size(), FL);
    for (int i = 0; i < FL; i++) check_val($sformatf("f2_byte%0d", i), qa(i), exp_f2[i]);

    // overflow: one in flight, four buffered, two dropped
    hold_busy = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) send(11'h100 + 11'(i));
    @(negedge clk);
    check_val("ovf_drop", drop, 2);
    check_val("ovf_no_trig", cap_q.size(), 0);
    check_val("ovf_active", act, 1);
    hold_busy = 1'b0;
    wait_done(3000, to);
    check_val("ovf_timeout", to, 0);
    check_val("ovf_len", cap_q.size(), 5 * FL);
    for (int f = 0; f < 5; f++) begin
      check_val($sformatf("ovf_seq%0d", f), qa(f*FL + 1), f);
      check_val($sformatf("ovf_hi%0d", f), qa(f*FL + 2), 8'h01);
      check_val($sformatf("ovf_lo%0d", f), qa(f*FL + 3), f);
    end

    // sequence wrap
    do_reset();
    busy_len = 0;
    tos = 0; errs = 0;
    for (int f = 0; f < 258; f++) begin
      cap_q.delete();
      send(11'(f));
      wait_done(100, to);
      tos += int'(to);
      if (qa(1) != (f & 255)) errs++;
      if (f >= 255) check_val($sformatf("wrap_seq_f%0d", f), qa(1), f & 255);
    end
    check_val("wrap_timeouts", tos, 0);
    check_val("wrap_seq_all", errs, 0);

    // drop counter saturation
    hold_busy = 1'b1;
    do_reset();
    @(negedge clk);
    val = 11'h077; vld = 1'b1;
    repeat (5 + 65534) @(negedge clk);
    check_val("drop_fffe", drop, 16'hFFFE);
    repeat (3) @(negedge clk);
    vld = 1'b0;
    check_val("drop_sat", drop, 16'hFFFF);
    hold_busy = 1'b0;
    busy_len = 2;
    wait_done(2000, to);
    check_val("drain_timeout", to, 0);

    // reset in the middle of a frame
    cap_q.delete();
    send(11'h5A3);
    k = 0;
    while (cap_q.size() < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_val("mid_two_bytes", cap_q.size(), 2);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!ua.trigger_out && k < 50);
    found = ua.trigger_out;
    check_val("mid_found", found, 1);
    rst = 1'b1;
    #1;
    check_val("mid_trig_same", ua.trigger_out, 0);
    @(posedge clk);
    #1;
    check_val("mid_data", ua.data_byte_out, 0);
    check_val("mid_trig", ua.trigger_out, 0);
    check_val("mid_active", act, 0);
    check_val("mid_drop", drop, 0);
    check_val("mid_no_partial", cap_q.size(), 2);
    @(negedge clk);
    rst = 1'b0;
    cap_q.delete();
    send(11'h0AB);
    wait_done(400, to);
    check_val("post_timeout", to, 0);
    check_val("post_len", cap_q.size(), FL);
    check_val("post_sync", qa(0), 8'hA5);
    check_val("post_seq", qa(1), 8'h00);
    check_val("post_lo", qa(3), 8'hAB);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
